// File: rtl/gomoku_pkg.sv
// gomoku_pkg: shared constants and types for the gomoku judge.
//   BOARD_N / CELLS / WIN_LEN : board geometry and winning run length
//   state_t                   : judge scan state machine encoding
//   WIN_*                     : winner output codes
//   DIR_DR / DIR_DC           : row/column delta for the four scan directions
//   probe_step                : signed offset of the k-th probe along a direction
package gomoku_pkg;

    localparam int BOARD_N = 15;
    localparam int CELLS   = 225;
    localparam int WIN_LEN = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        POS  = 3'd1,
        NEG  = 3'd2,
        EVAL = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_HUMAN = 2'b01;
    localparam logic [1:0] WIN_CPU   = 2'b10;
    localparam logic [1:0] WIN_DRAW  = 2'b11;

    // Directions: horizontal, vertical, diagonal, anti-diagonal.
    localparam logic signed [1:0] DIR_DR [4] = '{2'sd0, 2'sd1, 2'sd1,  2'sd1};
    localparam logic signed [1:0] DIR_DC [4] = '{2'sd1, 2'sd0, 2'sd1, -2'sd1};

    // Offset k*d (or -k*d when scanning the negative side); d is -1, 0 or +1.
    function automatic logic signed [5:0] probe_step(input logic signed [1:0] d,
                                                     input logic [2:0]        k,
                                                     input logic              neg);
        logic signed [5:0] kk;
        logic signed [1:0] de;
        kk = $signed({3'b000, k});
        de = neg ? -d : d;
        if (de == 2'sd1)
            return kk;
        else if (de == -2'sd1)
            return -kk;
        return 6'sd0;
    endfunction

endpackage

// File: rtl/gomoku_judge_if.sv
// gomoku_judge_if: move request / board / verdict bundle of the gomoku judge.
//   pressed, move_row, move_col  : move commit from the keyboard player
//   board_human, board_cpu       : stone bitmaps, bit index = row*15+col
//   is_player, busy, game_over,
//   winner, move_count           : judge status back to the game
// Modports: master (game side), slave (judge side).
interface gomoku_judge_if;

    logic                          pressed;
    logic [3:0]                    move_row;
    logic [3:0]                    move_col;
    logic [gomoku_pkg::CELLS-1:0]  board_human;
    logic [gomoku_pkg::CELLS-1:0]  board_cpu;
    logic                          is_player;
    logic                          busy;
    logic                          game_over;
    logic [1:0]                    winner;
    logic [7:0]                    move_count;

    modport master (
        output pressed, move_row, move_col, board_human, board_cpu,
        input  is_player, busy, game_over, winner, move_count
    );

    modport slave (
        input  pressed, move_row, move_col, board_human, board_cpu,
        output is_player, busy, game_over, winner, move_count
    );

endinterface

// File: rtl/gomoku_cell_probe.sv
// gomoku_cell_probe: combinational bounds check and cell lookup.
//   i_row, i_col : signed probe coordinates (may fall off the board)
//   i_board      : stone bitmap, bit index = row*15+col
//   o_on_board   : coordinates lie inside the 15x15 board
//   o_cell       : stone present at the probed cell (0 when off-board)
module gomoku_cell_probe
    import gomoku_pkg::*;
(
    input  logic signed [5:0]   i_row,
    input  logic signed [5:0]   i_col,
    input  logic [CELLS-1:0]    i_board,
    output logic                o_on_board,
    output logic                o_cell
);

    localparam logic signed [5:0] N_S = 6'(BOARD_N);

    logic       w_on_board;
    logic [7:0] w_idx;
    logic [7:0] w_idx_safe;

    assign w_on_board = (i_row >= 6'sd0) && (i_row < N_S) &&
                        (i_col >= 6'sd0) && (i_col < N_S);
    assign w_idx      = {4'b0000, i_row[3:0]} * 8'(BOARD_N) + {4'b0000, i_col[3:0]};
    // Off-board coordinates can alias past the last cell; pin them to 0.
    assign w_idx_safe = w_on_board ? w_idx : 8'd0;

    assign o_on_board = w_on_board;
    assign o_cell     = w_on_board & i_board[w_idx_safe];

endmodule

// File: rtl/gomoku_judge.sv
// gomoku_judge: win/draw judge for a 15x15 gomoku board.
// On each accepted move it scans the four directions through the new stone,
// one cell per cycle, and reports a win, a draw on the 225th move, or hands
// the turn to the other side.
//   clk  : system clock
//   rst  : synchronous active-low reset
//   bus  : gomoku_judge_if.slave (move request in, boards in, verdict out)
// Build option: JUDGE_EXACT_FIVE_EN -- only an exact run of five wins.
module gomoku_judge
    import gomoku_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    gomoku_judge_if.slave   bus
);

    state_t      r_state, w_state_n;
    logic        r_pressed_q;
    logic        r_is_player, w_is_player_n;
    logic        r_game_over, w_game_over_n;
    logic [1:0]  r_winner, w_winner_n;
    logic [7:0]  r_move_count, w_move_count_n;
    logic [1:0]  r_dir, w_dir_n;
    logic [2:0]  r_k, w_k_n;
    logic [2:0]  r_pos_hits, w_pos_hits_n;
    logic [2:0]  r_neg_hits, w_neg_hits_n;
    logic        r_win, w_win_n;
    logic        r_mover, w_mover_n;
    logic [3:0]  r_row, w_row_n;
    logic [3:0]  r_col, w_col_n;

    logic              w_req;
    logic              w_neg;
    logic signed [5:0] w_prow;
    logic signed [5:0] w_pcol;
    logic [CELLS-1:0]  w_board;
    logic              w_on_board;
    logic              w_cell;
    logic              w_hit;
    logic [3:0]        w_run;
    logic              w_is_win;

    assign w_req   = bus.pressed & ~r_pressed_q;
    assign w_neg   = (r_state == NEG);
    assign w_prow  = $signed({2'b00, r_row}) + probe_step(DIR_DR[r_dir], r_k, w_neg);
    assign w_pcol  = $signed({2'b00, r_col}) + probe_step(DIR_DC[r_dir], r_k, w_neg);
    assign w_board = r_mover ? bus.board_human : bus.board_cpu;
    assign w_hit   = w_on_board & w_cell;
    assign w_run   = 4'd1 + {1'b0, r_pos_hits} + {1'b0, r_neg_hits};

`ifdef JUDGE_EXACT_FIVE_EN
    assign w_is_win = (w_run == 4'(WIN_LEN));
`else
    assign w_is_win = (w_run >= 4'(WIN_LEN));
`endif

    gomoku_cell_probe u_probe (
        .i_row      (w_prow),
        .i_col      (w_pcol),
        .i_board    (w_board),
        .o_on_board (w_on_board),
        .o_cell     (w_cell)
    );

    always_comb begin
        w_state_n      = r_state;
        w_is_player_n  = r_is_player;
        w_game_over_n  = r_game_over;
        w_winner_n     = r_winner;
        w_move_count_n = r_move_count;
        w_dir_n        = r_dir;
        w_k_n          = r_k;
        w_pos_hits_n   = r_pos_hits;
        w_neg_hits_n   = r_neg_hits;
        w_win_n        = r_win;
        w_mover_n      = r_mover;
        w_row_n        = r_row;
        w_col_n        = r_col;

        case (r_state)
            IDLE: begin
                if (w_req && !r_game_over) begin
                    w_row_n   = bus.move_row;
                    w_col_n   = bus.move_col;
                    w_mover_n = r_is_player;
                    // Off-board coordinates are consumed without any effect.
                    if (bus.move_row <= 4'd14 && bus.move_col <= 4'd14) begin
                        w_move_count_n = r_move_count + 8'd1;
                        w_state_n      = POS;
                        w_dir_n        = 2'd0;
                        w_k_n          = 3'd1;
                        w_pos_hits_n   = 3'd0;
                        w_neg_hits_n   = 3'd0;
                        w_win_n        = 1'b0;
                    end
                end
            end
            POS: begin
                if (!w_hit || r_k == 3'd5) begin
                    w_state_n = NEG;
                    w_k_n     = 3'd1;
                end else begin
                    w_k_n     = r_k + 3'd1;
                end
                if (w_hit)
                    w_pos_hits_n = r_pos_hits + 3'd1;
            end
            NEG: begin
                if (!w_hit || r_k == 3'd5)
                    w_state_n = EVAL;
                else
                    w_k_n     = r_k + 3'd1;
                if (w_hit)
                    w_neg_hits_n = r_neg_hits + 3'd1;
            end
            EVAL: begin
                if (w_is_win) begin
                    w_win_n   = 1'b1;
                    w_state_n = DONE;
                end else if (r_dir == 2'd3) begin
                    w_state_n = DONE;
                end else begin
                    w_dir_n      = r_dir + 2'd1;
                    w_k_n        = 3'd1;
                    w_pos_hits_n = 3'd0;
                    w_neg_hits_n = 3'd0;
                    w_state_n    = POS;
                end
            end
            DONE: begin
                w_state_n = IDLE;
                if (r_win) begin
                    w_winner_n    = r_mover ? WIN_HUMAN : WIN_CPU;
                    w_game_over_n = 1'b1;
                end else if (r_move_count == 8'(CELLS)) begin
                    w_winner_n    = WIN_DRAW;
                    w_game_over_n = 1'b1;
                end else begin
                    w_is_player_n = ~r_is_player;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_pressed_q  <= 1'b1;   // a level held through reset is not an edge
            r_is_player  <= 1'b1;
            r_game_over  <= 1'b0;
            r_winner     <= WIN_NONE;
            r_move_count <= 8'd0;
            r_dir        <= 2'd0;
            r_k          <= 3'd1;
            r_pos_hits   <= 3'd0;
            r_neg_hits   <= 3'd0;
            r_win        <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_pressed_q  <= bus.pressed;
            r_is_player  <= w_is_player_n;
            r_game_over  <= w_game_over_n;
            r_winner     <= w_winner_n;
            r_move_count <= w_move_count_n;
            r_dir        <= w_dir_n;
            r_k          <= w_k_n;
            r_pos_hits   <= w_pos_hits_n;
            r_neg_hits   <= w_neg_hits_n;
            r_win        <= w_win_n;
        end
    end

    always_ff @(posedge clk) begin
        r_mover <= w_mover_n;
        r_row   <= w_row_n;
        r_col   <= w_col_n;
    end

    assign bus.is_player  = r_is_player;
    assign bus.busy       = (r_state != IDLE);
    assign bus.game_over  = r_game_over;
    assign bus.winner     = r_winner;
    assign bus.move_count = r_move_count;

endmodule

// File: tb/tb_gomoku_judge.sv
// tb_gomoku_judge: directed self-checking bench for gomoku_judge.
// Honours JUDGE_EXACT_FIVE_EN for the overline case.
module tb_gomoku_judge;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc;

    always #5 clk = ~clk;

    gomoku_judge_if bus ();

    gomoku_judge dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic hold_pressed);
        @(negedge clk);
        rst             = 1'b0;
        bus.pressed     = hold_pressed;
        bus.move_row    = 4'd0;
        bus.move_col    = 4'd0;
        bus.board_human = '0;
        bus.board_cpu   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic put_stone(input logic human, input int r, input int c);
        if (human)
            bus.board_human[r*15+c] = 1'b1;
        else
            bus.board_cpu[r*15+c] = 1'b1;
    endtask

    // Raise pressed with the given move, then wait (bounded) for busy to drop.
    // With extra set, a second rising edge is produced while the scan runs.
    task automatic do_move(input logic [3:0] r, input logic [3:0] c,
                           input logic extra, output int ncyc);
        @(negedge clk);
        bus.move_row = r;
        bus.move_col = c;
        bus.pressed  = 1'b1;
        @(negedge clk);
        ncyc = 1;
        if (extra) begin
            bus.pressed = 1'b0;
            @(negedge clk);
            ncyc++;
            bus.pressed = 1'b1;
        end
        while (bus.busy && ncyc < 60) begin
            @(negedge clk);
            ncyc++;
        end
        bus.pressed = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.pressed     = 1'b0;
        bus.move_row    = 4'd0;
        bus.move_col    = 4'd0;
        bus.board_human = '0;
        bus.board_cpu   = '0;

        // Reset state, pressed held high through release
        do_reset(1'b1);
        chk("rst_is_player", bus.is_player, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_game_over", bus.game_over, 0);
        chk("rst_winner", bus.winner, 0);
        chk("rst_move_count", bus.move_count, 0);
        repeat (3) @(negedge clk);
        chk("held_busy", bus.busy, 0);
        chk("held_move_count", bus.move_count, 0);
        bus.pressed = 1'b0;
        @(negedge clk);

        // Off-board request
        do_move(4'd15, 4'd3, 1'b0, cyc);
        chk("inv_move_count", bus.move_count, 0);
        chk("inv_is_player", bus.is_player, 1);
        chk("inv_busy", bus.busy, 0);

        // Single stone at the corner plus an edge while busy
        put_stone(1'b1, 0, 0);
        do_move(4'd0, 4'd0, 1'b1, cyc);
        chk("single_latency", (cyc <= 46) ? 1 : 0, 1);
        chk("single_move_count", bus.move_count, 1);
        chk("single_is_player", bus.is_player, 0);
        chk("single_winner", bus.winner, 0);
        chk("single_game_over", bus.game_over, 0);

        // Reset in the middle of a scan
        do_reset(1'b0);
        put_stone(1'b1, 7, 7);
        @(negedge clk);
        bus.move_row = 4'd7;
        bus.move_col = 4'd7;
        bus.pressed  = 1'b1;
        repeat (3) @(negedge clk);
        rst         = 1'b0;
        bus.pressed = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_move_count", bus.move_count, 0);
        chk("abort_winner", bus.winner, 0);
        chk("abort_is_player", bus.is_player, 1);

        // Horizontal human five ending at (7,7)
        do_reset(1'b0);
        for (int c = 3; c <= 7; c++) put_stone(1'b1, 7, c);
        do_move(4'd7, 4'd7, 1'b0, cyc);
        chk("horiz_latency", (cyc <= 46) ? 1 : 0, 1);
        chk("horiz_winner", bus.winner, 1);
        chk("horiz_game_over", bus.game_over, 1);
        chk("horiz_is_player", bus.is_player, 1);
        chk("horiz_busy", bus.busy, 0);
        chk("horiz_move_count", bus.move_count, 1);
        do_move(4'd7, 4'd8, 1'b0, cyc);
        chk("horiz_after_count", bus.move_count, 1);
        chk("horiz_after_winner", bus.winner, 1);

        // CPU anti-diagonal five, completed in the middle at (4,10)
        do_reset(1'b0);
        put_stone(1'b1, 14, 14);
        do_move(4'd14, 4'd14, 1'b0, cyc);
        chk("adiag_turn", bus.is_player, 0);
        for (int i = 0; i < 5; i++) put_stone(1'b0, 2 + i, 12 - i);
        do_move(4'd4, 4'd10, 1'b0, cyc);
        chk("adiag_latency", (cyc <= 46) ? 1 : 0, 1);
        chk("adiag_winner", bus.winner, 2);
        chk("adiag_game_over", bus.game_over, 1);
        chk("adiag_is_player", bus.is_player, 0);
        chk("adiag_move_count", bus.move_count, 2);

        // Overline of six human stones
        do_reset(1'b0);
        for (int c = 0; c <= 5; c++) put_stone(1'b1, 9, c);
        do_move(4'd9, 4'd5, 1'b0, cyc);
`ifdef JUDGE_EXACT_FIVE_EN
        chk("six_winner", bus.winner, 0);
        chk("six_game_over", bus.game_over, 0);
        chk("six_is_player", bus.is_player, 0);
`else
        chk("six_winner", bus.winner, 1);
        chk("six_game_over", bus.game_over, 1);
        chk("six_is_player", bus.is_player, 1);
`endif

        // Draw on the 225th move (empty bitmaps never produce a run)
        do_reset(1'b0);
        for (int i = 0; i < 224; i++)
            do_move(4'(i % 15), 4'(i / 15), 1'b0, cyc);
        chk("draw_pre_count", bus.move_count, 224);
        chk("draw_pre_winner", bus.winner, 0);
        chk("draw_pre_game_over", bus.game_over, 0);
        do_move(4'd14, 4'd14, 1'b0, cyc);
        chk("draw_winner", bus.winner, 3);
        chk("draw_game_over", bus.game_over, 1);
        chk("draw_move_count", bus.move_count, 225);
        do_move(4'd0, 4'd0, 1'b0, cyc);
        chk("draw_after_count", bus.move_count, 225);
        chk("draw_after_winner", bus.winner, 3);
        chk("draw_after_busy", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
